// File: rtl/axis_nibble_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_nibble_pkg
//  Purpose  : Shared constants, types and helpers for the nibble unpacker.
//             Keep encodings, length sanitising, nibble masks and the
//             unpacker state enumeration.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axis_nibble_pkg;

    localparam int NIB_W = 4;   // bits per nibble
    localparam int CNT_W = 4;   // buffer occupancy width, holds 0..8

    localparam logic [7:0] KEEP_4  = 8'd4;
    localparam logic [7:0] KEEP_8  = 8'd8;
    localparam logic [7:0] KEEP_12 = 8'd12;
    localparam logic [7:0] KEEP_16 = 8'd16;

    // FILL  : waiting for enough nibbles, no packet end buffered
    // EMIT  : a fragment was issued last cycle and no packet end is buffered
    // DRAIN : the buffer holds the tail of a packet; input blocked until empty
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bit-count keep to nibble count; anything unexpected is a full beat.
    function automatic logic [2:0] keep_to_nib(input logic [7:0] keep);
        logic [2:0] n;
        case (keep)
            KEEP_4:  n = 3'd1;
            KEEP_8:  n = 3'd2;
            KEEP_12: n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Requested length of 0 or above 4 nibbles means a full 4-nibble fragment.
    function automatic logic [2:0] len_sanitize(input logic [2:0] len);
        logic [2:0] n;
        if (len == 3'd0 || len > 3'd4) begin
            n = 3'd4;
        end else begin
            n = len;
        end
        return n;
    endfunction

    // Mask selecting the low n nibbles of a beat.
    function automatic logic [15:0] nib_mask(input logic [2:0] n);
        logic [15:0] m;
        case (n)
            3'd1:    m = 16'h000F;
            3'd2:    m = 16'h00FF;
            3'd3:    m = 16'h0FFF;
            3'd4:    m = 16'hFFFF;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_nibble_unpacker_shift_buf.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_shift_buf
//  Purpose  : Nibble FIFO with parallel append and head removal. Each cycle
//             pop_n nibbles leave from position 0, the rest shift down, and
//             push_n nibbles from the low end of push_data append behind
//             the shifted remainder. Storage above cnt is kept zero.
//  Ports    : clk, areset       - clock, synchronous active-high reset
//             push_n_i          - nibbles to append (0..4)
//             push_data_i       - source beat, nibble 0 in bits 3:0
//             pop_n_i           - nibbles to remove (0..4, never above cnt)
//             head_o            - lowest NIB nibbles of the buffer
//             cnt_o             - current occupancy in nibbles
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_shift_buf
    import axis_nibble_pkg::*;
#(
    parameter int NIB     = 4,
    parameter int BUF_NIB = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [2:0]             push_n_i,
    input  logic [NIB*NIB_W-1:0]   push_data_i,
    input  logic [2:0]             pop_n_i,
    output logic [NIB*NIB_W-1:0]   head_o,
    output logic [CNT_W-1:0]       cnt_o
);

    logic [BUF_NIB*NIB_W-1:0] buf_q, buf_d;
    logic [BUF_NIB*NIB_W-1:0] kept, incoming;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         remain;

    always_comb begin
        remain   = cnt_q - {1'b0, pop_n_i};
        // Right shift fills zeros, keeping the region above cnt clean.
        kept     = buf_q >> {pop_n_i, 2'b00};
        incoming = {{((BUF_NIB-NIB)*NIB_W){1'b0}}, push_data_i & nib_mask(push_n_i)};
        // New nibbles land directly behind whatever survived the pop.
        buf_d    = kept | (incoming << {remain, 2'b00});
        cnt_d    = remain + {1'b0, push_n_i};
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o = buf_q[NIB*NIB_W-1:0];
    assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/axis_nibble_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : axis_nibble_unpacker
//  Purpose  : Splits a densely packed 16-bit nibble stream back into
//             variable-width fragments (1..4 nibbles) whose lengths arrive on
//             a separate length stream. Fragments are right-aligned with a
//             bit-count tkeep; tlast marks the fragment holding the final
//             nibble of a packet.
//  Ports    : clk, areset          - clock, synchronous active-high reset
//             s_axis_*             - packed input (tdata/tvalid/tready/tlast/tkeep)
//             l_axis_*             - fragment length requests (tdata/tvalid/tready)
//             m_axis_*             - fragment output (tdata/tvalid/tready/tlast/tkeep)
//  Revision : 1.0 - initial release
// ============================================================================
module axis_nibble_unpacker
    import axis_nibble_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NIB        = 4,
    parameter int BUF_NIB    = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [7:0]            s_axis_tkeep,
    input  logic [2:0]            l_axis_tdata,
    input  logic                  l_axis_tvalid,
    output logic                  l_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [7:0]            m_axis_tkeep
);

    state_t                state_q, state_d;

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            len, in_n, take_n, push_n, pop_n;
    logic                  eop_buf, in_open, out_free, fire, s_hs, drained;

    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q,  m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q,  m_data_d;
    logic [7:0]            m_keep_q,  m_keep_d;

    nibble_shift_buf #(
        .NIB     (NIB),
        .BUF_NIB (BUF_NIB)
    ) u_buf (
        .clk         (clk),
        .areset      (areset),
        .push_n_i    (push_n),
        .push_data_i (s_axis_tdata),
        .pop_n_i     (pop_n),
        .head_o      (head),
        .cnt_o       (cnt)
    );

    // ------------------------------------------------------------------
    // Handshake / fire datapath
    // ------------------------------------------------------------------
    always_comb begin
        len      = len_sanitize(l_axis_tdata);
        in_n     = keep_to_nib(s_axis_tkeep);
        out_free = !m_valid_q || m_axis_tready;
        take_n   = ({1'b0, len} < cnt) ? len : cnt[2:0];
        // With a packet end buffered, a short remainder may go out early.
        fire     = !areset && l_axis_tvalid && out_free &&
                   ((cnt >= {1'b0, len}) || (eop_buf && cnt != '0));
        s_hs     = s_axis_tvalid && s_axis_tready;
        push_n   = s_hs ? in_n   : 3'd0;
        pop_n    = fire ? take_n : 3'd0;
        drained  = fire && ({1'b0, take_n} == cnt);
    end

    assign l_axis_tready = fire;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL, ST_EMIT: begin
                // Input is only accepted outside DRAIN, so a tlast beat and
                // a draining fire can never coincide here.
                if (s_hs && s_axis_tlast) begin
                    state_d = ST_DRAIN;
                end else if (fire) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The packet-end flag lives in the DRAIN state itself,
    // which also guarantees two packets never share the buffer.
    // ------------------------------------------------------------------
    always_comb begin
        eop_buf       = (state_q == ST_DRAIN);
        in_open       = !eop_buf;
        s_axis_tready = in_open && (cnt <= CNT_W'(NIB)) && !areset;
    end

    // ------------------------------------------------------------------
    // Output register: loads on fire, holds under backpressure
    // ------------------------------------------------------------------
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        if (fire) begin
            m_valid_d = 1'b1;
            m_data_d  = head & nib_mask(take_n);
            m_keep_d  = {3'b000, take_n, 2'b00};
            m_last_d  = eop_buf && ({1'b0, take_n} == cnt);
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;

endmodule
`default_nettype wire

// File: doc/axis_nibble_unpacker.md
Name: axis_nibble_unpacker

Overview:
- Receive side of the nibble-packing AXI-Stream path; the inverse of the packer.
- Takes a densely packed 16-bit nibble stream and a side channel of fragment lengths.
- Re-emits variable-width fragments, right-aligned, 1 to 4 nibbles each, with bit-count tkeep.
- Sits between the packed transport link and consumers that expect the original unaligned beats.

Parameters:
DATA_WIDTH, 16, beat width in bits; must equal 4*NIB.
NIB, 4, nibbles per beat.
BUF_NIB, 8, internal nibble buffer depth; must be 2*NIB.

Ports:
clk  input  1  clock
areset  input  1  reset, synchronous, active-high
s_axis_tdata  input  16  packed data; nibble 0 (bits 3:0) is oldest
s_axis_tvalid  input  1  input beat valid
s_axis_tready  output  1  input beat accepted
s_axis_tlast  input  1  last beat of packet
s_axis_tkeep  input  8  valid bit count of beat: 4, 8, 12 or 16; only the tlast beat may be below 16
l_axis_tdata  input  3  requested fragment length in nibbles, 1 to 4
l_axis_tvalid  input  1  length valid
l_axis_tready  output  1  length consumed
m_axis_tdata  output  16  fragment, right-aligned, unused upper nibbles zero
m_axis_tvalid  output  1  fragment valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  fragment holds last nibble of packet
m_axis_tkeep  output  8  valid bit count of fragment (4 × nibbles)

Behaviour:
- Reset values: s_axis_tready=0, l_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
- Internal state: buffer count cnt (0..8) and flag eop_buf (buffer holds the end of a packet).
- Nibble buffer: BUF_NIB nibbles, FIFO order. Input nibbles append at position cnt. Fragments remove from position 0 and shift the remainder down.
- Input accept: s_axis_tready = (cnt <= 4) && !eop_buf && !areset. On a handshake, append tkeep/4 nibbles from the low end of tdata. If tlast, set eop_buf.
- tkeep not in {4, 8, 12, 16} is treated as 16. l_axis_tdata of 0 or greater than 4 is treated as 4.
- Fire condition: l_axis_tvalid && out_free && (cnt >= len || (eop_buf && cnt > 0)), where out_free = !m_axis_tvalid || m_axis_tready.
- On fire, in one edge:
  - n = min(len, cnt).
  - Load the output register with n nibbles: tkeep = 4n, tlast = eop_buf && (n == cnt).
  - Pulse l_axis_tready for that cycle.
  - Remove n nibbles. Clear eop_buf if the buffer empties.
- Truncation: a length request longer than the packet remainder produces a short fragment with tlast=1. The full length token is consumed.
- Simultaneous accept and fire in the same cycle: cnt_next = cnt + in_n − n. The appended nibbles land after the shifted remainder.
- Latency: beat accepted at edge N; the earliest m_axis_tvalid is after edge N+1 (2 cycles). Sustained throughput is 1 fragment per cycle.
- Output hold: m_axis_tvalid/tdata/tkeep/tlast stay stable while m_axis_tvalid && !m_axis_tready. m_axis_tvalid deasserts after a handshake with no new fire.
- State machine:
  - FILL: cnt < len and !eop_buf. Wait for input.
  - EMIT: fire possible. Stay while the fire condition holds.
  - DRAIN: eop_buf set. Input blocked; emit until cnt=0, then go to FILL.
  - Transitions follow the combinational conditions above; reset enters FILL.
- Packet boundary: nibbles from the next packet are never merged into a fragment with the previous packet's tail.
- Reset mid-operation: buffer, eop_buf and the output register are cleared in 1 cycle. A pending length token is dropped (l_axis_tready=0 during reset).

Decomposition:
- Package axis_nibble_pkg:
  - NIB_W=4.
  - Keep encodings KEEP_4/8/12/16.
  - Function keep_to_nib (with the illegal→16 rule).
  - Function len_sanitize.
  - State enum {FILL, EMIT, DRAIN}.
- One sub-module: nibble_shift_buf. It owns the 8-nibble storage, the append-at-cnt logic, the remove-from-head shift and cnt. Ports: push_n, push_data, pop_n, head (lowest 4 nibbles), cnt.
- Top level holds the FSM, handshakes and output register.

Test Plan:
- Beats 0x4321 (keep 16) and 0x8765 (keep 16, tlast); lengths 3, 3, 2, m_ready=1 → 0x0321 keep 12, 0x0654 keep 12, 0x0087 keep 8 tlast=1.
- Beat 0x00A9 (keep 8, tlast); length 4 → 0x00A9 keep 8 tlast=1; length token consumed; next packet accepted afterwards.
- Continuous keep-16 beats 0x1111 to 0x4444 with length 4 and m_ready=1 → first m_axis_tvalid 2 cycles after the first handshake, then one fragment per cycle equal to each input beat.
- m_axis_tready held low for 5 cycles with valid pending → output fields unchanged. s_axis_tready falls once cnt>4. No nibble lost or duplicated after release.
- Packet A ends with 1 nibble left, packet B queued; length 4 → fragment 0x000X keep 4 tlast=1. B's first fragment starts at B nibble 0.
- areset asserted with cnt=5 and output valid → next cycle all outputs zero and cnt=0. A subsequent beat 0x00FF keep 8 tlast with length 2 → 0x00FF keep 8 tlast=1.
